tile_line_buffer: RTL

Double-buffered scanline store that sits between the tile fetch engine and the VGA pixel path. It issues the per-line fetch trigger, accepts 16-pixel tile rows (tile column plus 256-bit row data) and writes them into the back bank. It swaps banks at the end of every line and streams 16-bit pixels from the front bank in step with the display counters. It also flags lines whose fetch did not complete in time.

---
 rtl/tile_line_buffer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/tile_line_buffer.sv
// tile_line_buffer: double-buffered scanline store between the tile fetch
// engine and the VGA pixel path. Tile rows are written into the back bank
// while the front bank is streamed out as 16-bit pixels. The banks swap at
// the last count of every line. A sticky flag records any line whose fetch
// was still incomplete when the swap happened.
module tile_line_buffer #(
    parameter int NUM_TILES = 40,
    parameter int HSWAP     = 1599,
    parameter int HFETCH    = 1280
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [10:0]  hcount,
    input  logic [9:0]   vcount,
    output logic         tile_start,
    input  logic         tile_valid,
    input  logic [5:0]   tile_col,
    input  logic [255:0] tile_data,
    input  logic         tile_done,
    output logic [15:0]  pixel,
    output logic         pixel_active,
    output logic         underrun,
    input  logic         underrun_clr
);

    // Visible window and the last vertical count (line 0 follows it).
    localparam int HACTIVE = 1280;
    localparam int VACTIVE = 480;
    localparam int VLAST   = 524;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } fetch_state_t;

    fetch_state_t          r_state;
    logic                  r_wr_bank;
    logic [NUM_TILES-1:0]  r_fill_mask;
    logic                  r_tile_done_d;

    logic [255:0]          r_bank0 [NUM_TILES];
    logic [255:0]          r_bank1 [NUM_TILES];
    logic [255:0]          r_rd_data;
    logic [3:0]            r_rd_px;
    logic                  r_rd_active;

    logic                  w_hfetch;
    logic                  w_hswap;
    logic                  w_wr_en;
    logic [NUM_TILES-1:0]  w_wr_bits;
    logic                  w_mask_full;
    logic                  w_next_visible;
    logic                  w_done_rise;
    logic                  w_underrun_set;
    logic                  w_rd_active;
    logic [5:0]            w_rd_tile;
    logic [3:0]            w_rd_px;

    // Decode line events, write qualification and read addressing
    always_comb begin
        w_hfetch       = (hcount == 11'(HFETCH));
        w_hswap        = (hcount == 11'(HSWAP));
        w_wr_en        = tile_valid && ({1'b0, tile_col} < 7'(NUM_TILES));
        if (w_wr_en) begin
            w_wr_bits = {{(NUM_TILES-1){1'b0}}, 1'b1} << tile_col;
        end else begin
            w_wr_bits = '0;
        end
        w_mask_full    = &r_fill_mask;
        // The line after the current one is visible (524 wraps to line 0).
        w_next_visible = (vcount < 10'(VACTIVE - 1)) || (vcount == 10'(VLAST));
        w_done_rise    = tile_done && !r_tile_done_d;
        w_underrun_set = w_hswap && !w_mask_full && w_next_visible;
        w_rd_active    = (hcount < 11'(HACTIVE)) && (vcount < 10'(VACTIVE));
        w_rd_tile      = hcount[10:5];
        w_rd_px        = hcount[4:1];
    end

    // Fetch sequencing, fill tracking, bank swap and the sticky underrun flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_wr_bank     <= 1'b0;
            r_fill_mask   <= '0;
            r_tile_done_d <= 1'b0;
            tile_start    <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            r_tile_done_d <= tile_done;

            // A new underrun takes priority over a clear in the same cycle.
            if (w_underrun_set) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end else begin
                underrun <= underrun;
            end

            // The swap happens every line whatever the fetch progress; a write
            // on the swap cycle still lands in the old back bank.
            if (w_hswap) begin
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_bank <= r_wr_bank;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_hfetch) begin
                        tile_start  <= 1'b1;
                        r_fill_mask <= w_wr_bits;
                        r_state     <= ST_FILL;
                    end else begin
                        tile_start  <= 1'b0;
                        r_fill_mask <= r_fill_mask | w_wr_bits;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    tile_start  <= 1'b0;
                    r_fill_mask <= r_fill_mask | w_wr_bits;
                    if (w_hswap) begin
                        r_state <= ST_IDLE;
                    end else if (w_mask_full || (w_done_rise && (r_fill_mask != '0))) begin
                        r_state <= ST_FULL;
                    end else begin
                        r_state <= ST_FILL;
                    end
                end
                ST_FULL: begin
                    tile_start  <= 1'b0;
                    r_fill_mask <= r_fill_mask | w_wr_bits;
                    if (w_hswap) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_FULL;
                    end
                end
                default: begin
                    tile_start  <= 1'b0;
                    r_fill_mask <= r_fill_mask;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Tile row storage: write the back bank, synchronously read the front bank
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            if (r_wr_bank) begin
                r_bank1[tile_col] <= tile_data;
            end else begin
                r_bank0[tile_col] <= tile_data;
            end
        end
        if (w_rd_active) begin
            r_rd_data <= r_wr_bank ? r_bank0[w_rd_tile] : r_bank1[w_rd_tile];
        end else begin
            r_rd_data <= '0;
        end
    end

    // Read pipeline: align pixel select/active with the RAM read, then register outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_active  <= 1'b0;
            r_rd_px      <= 4'd0;
            pixel        <= 16'd0;
            pixel_active <= 1'b0;
        end else begin
            r_rd_active  <= w_rd_active;
            r_rd_px      <= w_rd_px;
            pixel_active <= r_rd_active;
            if (r_rd_active) begin
                pixel <= r_rd_data[{r_rd_px, 4'd0} +: 16];
            end else begin
                pixel <= 16'd0;
            end
        end
    end

endmodule
